// File: rtl/serial_parity_frame_checker_pkg.sv
// rtl/serial_parity_frame_checker_pkg.sv - shared state encoding and parity constants
package serial_parity_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

  // x is the XOR of all data bits and the received parity bit
  function automatic logic parity_err(input logic x, input logic mode);
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear priority
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_parity_frame_checker.sv
// rtl/serial_parity_frame_checker.sv - LSB-first serial frame deserialiser with per-frame odd/even parity check
module serial_parity_frame_checker
  import serial_parity_frame_checker_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  input  logic              odd_mode,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              pec,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              run_par;
  logic              mode_odd;

  logic start;
  logic data_bit;
  logic complete;
  logic frame_pec;
  state_t start_tgt;

  assign start_tgt = (DATA_W == 1) ? ST_PARITY : ST_DATA;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    data_bit  = 1'b0;
    complete  = 1'b0;
    frame_pec = parity_err(run_par ^ bit_in, mode_odd);
    // sof with a valid bit always restarts, aborting any frame in flight
    if (bit_valid && sof) begin
      start     = 1'b1;
      state_nxt = start_tgt;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_DATA: begin
          if (bit_valid) begin
            data_bit = 1'b1;
            if (bit_cnt == LAST_IDX) state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            complete  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      run_par  <= 1'b0;
      mode_odd <= PAR_EVEN;
    end else if (start) begin
      shreg    <= '0;
      shreg[0] <= bit_in;
      bit_cnt  <= BC_W'(1);
      run_par  <= bit_in;
      mode_odd <= odd_mode;
    end else if (data_bit) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (bit_cnt == BC_W'(i)) shreg[i] <= bit_in;
      end
      bit_cnt <= bit_cnt + 1'b1;
      run_par <= run_par ^ bit_in;
    end else if (complete) begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      pec         <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= complete;
      busy        <= (state_nxt != ST_IDLE);
      if (complete) begin
        data_out <= shreg;
        pec      <= frame_pec;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (complete & frame_pec),
    .cnt (err_cnt)
  );

endmodule
